// File: rtl/reg_pipe_pkg.sv
// Shared types and helpers for the reg_pipe elastic register pipeline.
package reg_pipe_pkg;

  // Count width sized so that STAGES plus an optional skid entry always fits.
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 2);
  endfunction

  typedef struct packed {
    logic valid;
    logic load;
    logic advance;
  } stage_ctrl_t;

endpackage

// File: rtl/reg_pipe_if.sv
// Valid/ready stream bundle for reg_pipe: upstream port in_*, downstream port out_*.
interface reg_pipe_if #(
  parameter int WIDTH = 128
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: WIDTH-bit data register plus valid bit with load/hold/clear.
module reg_pipe_stage #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             v_in,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      // Only real entries overwrite the data register; bubbles leave it alone.
      if (v_in) begin
        q <= d;
      end
      valid <= v_in;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline with valid/ready backpressure, flush and occupancy count.
// Optional skid register in front of stage 0 when REG_PIPE_SKID_EN is defined.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  reg_pipe_if.slave                  bus,
  output logic [cnt_w(STAGES)-1:0]   count
);

  localparam int CW = cnt_w(STAGES);

  stage_ctrl_t      ctrl   [STAGES];
  logic             valid_q[STAGES];
  logic [WIDTH-1:0] data_q [STAGES];

  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             accept;
  logic             extra_valid;
  logic             nxt_load;
  logic [CW-1:0]    cnt_next;

  // Ready chain resolved from the output end back to stage 0.
  always_comb begin
    nxt_load = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ctrl[i].valid   = valid_q[i];
      ctrl[i].advance = nxt_load;
      ctrl[i].load    = !ctrl[i].valid || ctrl[i].advance;
      nxt_load        = ctrl[i].load;
    end
  end

`ifdef REG_PIPE_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign bus.in_ready = !skid_valid && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Skid catches an accepted word when stage 0 is blocked and drains first.
  reg_pipe_stage #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (!skid_valid || ctrl[0].load),
    .d     (bus.in_data),
    .v_in  (accept && !ctrl[0].load),
    .q     (skid_data),
    .valid (skid_valid)
  );

  assign head_valid  = skid_valid ? 1'b1 : accept;
  assign head_data   = skid_valid ? skid_data : bus.in_data;
  assign extra_valid = skid_valid;
`else
  assign bus.in_ready = ctrl[0].load && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign head_valid   = accept;
  assign head_data    = bus.in_data;
  assign extra_valid  = 1'b0;
`endif

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (gi == 0) begin : g_head
      assign d_in = head_data;
      assign v_in = head_valid;
    end else begin : g_chain
      assign d_in = data_q[gi-1];
      assign v_in = valid_q[gi-1];
    end

    reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .load  (ctrl[gi].load),
      .d     (d_in),
      .v_in  (v_in),
      .q     (data_q[gi]),
      .valid (valid_q[gi])
    );
  end

  always_comb begin
    cnt_next = CW'(extra_valid);
    for (int i = 0; i < STAGES; i++) begin
      cnt_next = cnt_next + CW'(ctrl[i].valid);
    end
  end

  assign count         = cnt_next;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];

endmodule
